// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared definitions for the iterative RV32M multiplier
// Contents: MUL_OP_* op encodings, mul_state_e FSM states, MUL_LATENCY.
package npc_pkg;

  localparam int MUL_LATENCY = 36;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } mul_state_e;

endpackage

// File: rtl/Adder32.sv
// rtl/Adder32.sv - 32-bit carry-lookahead adder
// Ports: c0 (carry in), in1/in2 (addends), sout (sum), cout (carry out).
// Built from eight 4-bit lookahead groups; group carries chain through the
// group generate/propagate terms.
module Adder32 (
  input  logic        c0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] sout,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;

  always_comb begin
    g     = in1 & in2;
    p     = in1 ^ in2;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = c0;
    for (int b = 0; b < 8; b++) begin
      // Carries inside a group depend only on the group carry-in.
      c[4*b+1] = g[4*b] | (p[4*b] & c[4*b]);
      c[4*b+2] = g[4*b+1] | (p[4*b+1] & g[4*b])
               | (p[4*b+1] & p[4*b] & c[4*b]);
      c[4*b+3] = g[4*b+2] | (p[4*b+2] & g[4*b+1])
               | (p[4*b+2] & p[4*b+1] & g[4*b])
               | (p[4*b+2] & p[4*b+1] & p[4*b] & c[4*b]);
      grp_g[b] = g[4*b+3] | (p[4*b+3] & g[4*b+2])
               | (p[4*b+3] & p[4*b+2] & g[4*b+1])
               | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
      grp_p[b] = &p[4*b +: 4];
      c[4*b+4] = grp_g[b] | (grp_p[b] & c[4*b]);
    end
    sout = p ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + op/src1/src2
// operand handshake; flush aborts the operation in flight; out_valid/out_ready
// + result (low word for MUL, high word otherwise) result handshake.
// Fixed 36-edge latency from the accepting edge to out_valid.
module mul_iter
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mul_state_e state_q;
  mul_state_e state_d;

  logic [1:0]      op_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            carry_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] result_q;

  logic            sa;
  logic            sb;
  logic            src1_neg;
  logic            src2_neg;
  logic            neg;

  logic            add_c0;
  logic [XLEN-1:0] add_in1;
  logic [XLEN-1:0] add_in2;
  logic [XLEN-1:0] add_sum;
  logic            add_cout;

  assign sa       = (op_q == MUL_OP_MULH) || (op_q == MUL_OP_MULHSU);
  assign sb       = (op_q == MUL_OP_MULH);
  assign src1_neg = sa & src1_q[XLEN-1];
  assign src2_neg = sb & src2_q[XLEN-1];
  assign neg      = src1_neg ^ src2_neg;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Single shared adder: negation is ~x + c0, accumulation is hi + (A or 0).
  always_comb begin
    add_c0  = 1'b0;
    add_in1 = '0;
    add_in2 = '0;
    case (state_q)
      ABS_A: begin
        add_in1 = src1_neg ? ~src1_q : src1_q;
        add_c0  = src1_neg;
      end
      ABS_B: begin
        add_in1 = src2_neg ? ~src2_q : src2_q;
        add_c0  = src2_neg;
      end
      MUL: begin
        add_in1 = hi_q;
        add_in2 = lo_q[0] ? a_q : '0;
      end
      NEG_LO: begin
        if (neg) begin
          add_in1 = ~lo_q;
          add_c0  = 1'b1;
        end
      end
      NEG_HI: begin
        if (neg) begin
          add_in1 = ~hi_q;
          add_c0  = carry_q;
        end
      end
      default: ;
    endcase
  end

  Adder32 u_adder (
    .c0   (add_c0),
    .in1  (add_in1),
    .in2  (add_in2),
    .sout (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      // Flush also blocks acceptance while idle.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = ABS_A;
        ABS_A:   state_d = ABS_B;
        ABS_B:   state_d = MUL;
        MUL:     if (cnt_q == 5'd31) state_d = NEG_LO;
        NEG_LO:  state_d = NEG_HI;
        NEG_HI:  state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !flush) begin
            op_q   <= op;
            src1_q <= src1;
            src2_q <= src2;
          end
        end
        ABS_A: a_q <= add_sum;
        ABS_B: begin
          lo_q  <= add_sum;
          hi_q  <= '0;
          cnt_q <= '0;
        end
        MUL: begin
          // Carry out of the accumulation becomes the new product MSB.
          {hi_q, lo_q} <= {add_cout, add_sum, lo_q[XLEN-1:1]};
          cnt_q        <= cnt_q + 5'd1;
        end
        NEG_LO: begin
          if (neg) begin
            lo_q    <= add_sum;
            carry_q <= add_cout;
          end else begin
            carry_q <= 1'b0;
          end
        end
        NEG_HI: begin
          if (neg) hi_q <= add_sum;
          // lo_q is already final here; hi comes straight from the adder.
          if (!flush) begin
            if (op_q == MUL_OP_MUL) result_q <= lo_q;
            else                    result_q <= neg ? add_sum : hi_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative RV32M multiplier that sits in EX beside the ALU and executes MUL, MULH, MULHSU and MULHU.
- Operands arrive from the ID/EX operand latch; the 32-bit result goes to the EX/WB select mux.
- It time-shares a single instance of the team's 32-bit carry-lookahead adder for operand negation, partial-product accumulation and result negation.
- Latency is a fixed 36 cycles, so stall logic can be kept simple.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- LATENCY, 36, edges from input acceptance to out_valid; this is derived and documented, not configurable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit idle and able to accept.
- op  in  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
- src1  in  32  rs1 value.
- src2  in  32  rs2 value.
- flush  in  1  pipeline kill; abort the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  low word for MUL, high word for the other three ops.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- Input handshake: an operation is accepted on an edge where in_valid && in_ready. op, src1 and src2 are captured on that edge.
- Operand signedness: src1 is signed for MULH and MULHSU; src2 is signed for MULH only.
- Result sign: neg = (sa && src1[31]) ^ (sb && src2[31]).
- States:
  - IDLE: in_ready=1. Leave on acceptance to ABS_A.
  - ABS_A (1 cycle): A = src1_neg ? ~src1+1 : src1+0. Computed on the adder with c0=1 or 0 and in2=0. A magnitude of 0x80000000 stays 0x80000000 (treated as unsigned).
  - ABS_B (1 cycle): same operation on src2 to produce B.
  - MUL (32 cycles, 5-bit counter 0..31): {hi,lo} form a 64-bit product register. lo is initialised to B, hi to 0.
    - Each cycle: {cout,sum} = hi + (lo[0] ? A : 0) with c0=0.
    - Then {hi,lo} <= {cout,sum,lo[31:1]}.
    - Counter wraps 31 to 0 and moves to NEG_LO.
  - NEG_LO (1 cycle): if neg, lo <= ~lo+1 and the carry is latched; otherwise lo is unchanged and carry=0.
  - NEG_HI (1 cycle): if neg, hi <= ~hi + carry. Then load result (op==MUL ? lo : hi) and go to DONE.
  - DONE: out_valid=1. result is held stable until out_ready.
- Output handshake: on out_valid && out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle accept from DONE.
- Timing: out_valid asserts after exactly 36 edges following the accepting edge. There is no early-out for zero operands.
- Adder use: exactly one adder instance. Its in1, in2 and c0 are muxed by state, and it is idle (inputs 0) in IDLE and DONE.
- Zero product with neg=1: negation of 0 gives 0, so the result is 0.
- flush:
  - Any non-IDLE state: return to IDLE on the next edge; out_valid drops and result is unchanged.
  - IDLE: flush has priority over in_valid, so nothing is accepted.
  - DONE with out_ready in the same cycle: flush wins and the result is discarded.
- Reset mid-operation: immediate return to reset values, with no output.
- in_valid while busy is ignored; in_ready=0 outside IDLE.

Decomposition:
- Shared package (npc_pkg):
  - MUL_OP_* 2-bit op encodings.
  - mul_state_e: IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE.
  - MUL_LATENCY=36.
- Sub-module: one instance of the existing Adder32 carry-lookahead adder (ports c0, in1, in2, sout, cout). There are no other sub-modules.

Test Plan:
- MUL, src1=3, src2=5 -> result=0x0000000F; out_valid exactly 36 cycles after accept.
- MUL, src1=0xFFFFFFF9 (-7), src2=3 -> 0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH, 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU, src1=0xFFFFFFFF, src2=2 -> 0xFFFFFFFF. MULHSU, src1=2, src2=0xFFFFFFFF -> 0x00000001.
- out_ready held 0 for 10 cycles after out_valid: result stable and in_ready=0; a new in_valid is ignored until the handshake completes.
- flush at MUL counter=10 -> IDLE next cycle and no out_valid. rst_n pulled low mid-NEG_LO -> outputs at reset values asynchronously. A next op MUL 6x7 -> 42.
